// File: rtl/mips_r2000_core.sv
`default_nettype none
// ============================================================================
//  Module      : mips_r2000_core (with sub-blocks mips_pcu, mips_imem,
//                mips_regfile, mips_dmem)
//  Description : Single-cycle 32-bit MIPS R2000 integer core. Fetch, decode,
//                execute, memory access and write-back complete in one clock.
//                Instruction memory, data memory, register file and PC unit
//                are internal; there are no external buses.
//  Ports       : CLK - system clock, all state updates on the rising edge
//                RST - synchronous active-low reset
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Program-counter register. Holds the full 32-bit PC.
// ----------------------------------------------------------------------------
module mips_pcu (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] i_next_pc,
    output logic      [31:0] o_pc
);
    logic [31:0] PCRegDataOut;

    always_ff @(posedge clk) begin
        if (!rst_n) PCRegDataOut <= 32'h0000_0000;
        else        PCRegDataOut <= i_next_pc;
    end

    assign o_pc = PCRegDataOut;
endmodule

// ----------------------------------------------------------------------------
// Instruction memory, 1024 words, combinational read. Contents are normally
// preloaded; the write port is tied off at the top level and is never reset,
// so preloaded code survives a core reset.
// ----------------------------------------------------------------------------
module mips_imem (
    input  wire logic        clk,
    input  wire logic        i_we,
    input  wire logic [9:0]  i_waddr,
    input  wire logic [31:0] i_wdata,
    input  wire logic [9:0]  i_raddr,
    output logic      [31:0] o_rdata
);
    logic [31:0] IMem [0:1023];

    always_ff @(posedge clk) begin
        if (i_we) IMem[i_waddr] <= i_wdata;
    end

    assign o_rdata = IMem[i_raddr];
endmodule

// ----------------------------------------------------------------------------
// 32x32 register file: two asynchronous read ports, one synchronous write
// port. $0 always reads zero and ignores writes. Reset clears all entries.
// ----------------------------------------------------------------------------
module mips_regfile (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [4:0]  i_ra1,
    input  wire logic [4:0]  i_ra2,
    output logic      [31:0] o_rd1,
    output logic      [31:0] o_rd2,
    input  wire logic        i_we,
    input  wire logic [4:0]  i_wa,
    input  wire logic [31:0] i_wd
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (i_we && (i_wa != 5'd0)) begin
            regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'h0 : regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'h0 : regs[i_ra2];
endmodule

// ----------------------------------------------------------------------------
// Data memory, 1024 words, combinational read, synchronous write. Not reset.
// ----------------------------------------------------------------------------
module mips_dmem (
    input  wire logic        clk,
    input  wire logic        i_we,
    input  wire logic [9:0]  i_addr,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_rdata
);
    logic [31:0] DMem [0:1023];

    always_ff @(posedge clk) begin
        if (i_we) DMem[i_addr] <= i_wdata;
    end

    assign o_rdata = DMem[i_addr];
endmodule

// ----------------------------------------------------------------------------
// Core top level: combinational decoder/ALU around the state-holding blocks.
// ----------------------------------------------------------------------------
module mips_r2000_core (
    input  wire logic CLK,
    input  wire logic RST
);
    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    // R-type function codes
    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_JALR = 6'h09;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_NOR  = 6'h27;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    wire  [31:0] instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_alu;
    logic [31:0] w_wd;
    logic [31:0] w_dmem_rdata;
    logic [4:0]  w_wa;
    logic        w_reg_we;
    logic        w_mem_we;
    logic        w_link;
    logic        w_load;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;
    logic [31:0] w_sext;
    logic [31:0] w_zext;

    assign w_op     = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_shamt  = instr[10:6];
    assign w_funct  = instr[5:0];
    assign w_imm    = instr[15:0];
    assign w_target = instr[25:0];
    assign w_sext   = {{16{w_imm[15]}}, w_imm};
    assign w_zext   = {16'h0000, w_imm};

    assign w_pc_plus4 = w_pc + 32'd4;

    mips_pcu U_PCU (
        .clk       (CLK),
        .rst_n     (RST),
        .i_next_pc (w_next_pc),
        .o_pc      (w_pc)
    );

    // Fetch indexes with PC[11:2], so fetch wraps every 4 KB.
    mips_imem U_InstructionMemory (
        .clk     (CLK),
        .i_we    (1'b0),
        .i_waddr (10'd0),
        .i_wdata (32'h0),
        .i_raddr (w_pc[11:2]),
        .o_rdata (instr)
    );

    mips_regfile U_RegFile (
        .clk   (CLK),
        .rst_n (RST),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rs_val),
        .o_rd2 (w_rt_val),
        .i_we  (w_reg_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd)
    );

    // Stores are blocked while reset is held so memory contents are preserved.
    mips_dmem U_DataMemory (
        .clk     (CLK),
        .i_we    (w_mem_we & RST),
        .i_addr  (w_alu[11:2]),
        .i_wdata (w_rt_val),
        .o_rdata (w_dmem_rdata)
    );

    // Decoder and ALU. Anything not matched falls through the defaults and
    // behaves as a NOP (no writes, PC+4).
    always_comb begin
        w_alu     = 32'h0;
        w_reg_we  = 1'b0;
        w_wa      = w_rd;
        w_mem_we  = 1'b0;
        w_link    = 1'b0;
        w_load    = 1'b0;
        w_next_pc = w_pc_plus4;
        case (w_op)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_FN_SLL:  begin w_alu = w_rt_val << w_shamt;  w_reg_we = 1'b1; end
                    c_FN_SRL:  begin w_alu = w_rt_val >> w_shamt;  w_reg_we = 1'b1; end
                    c_FN_SRA:  begin w_alu = $unsigned($signed(w_rt_val) >>> w_shamt); w_reg_we = 1'b1; end
                    c_FN_JR:   w_next_pc = w_rs_val;
                    c_FN_JALR: begin w_next_pc = w_rs_val; w_link = 1'b1; w_reg_we = 1'b1; end
                    c_FN_ADD, c_FN_ADDU: begin w_alu = w_rs_val + w_rt_val; w_reg_we = 1'b1; end
                    c_FN_SUB, c_FN_SUBU: begin w_alu = w_rs_val - w_rt_val; w_reg_we = 1'b1; end
                    c_FN_AND:  begin w_alu = w_rs_val & w_rt_val;    w_reg_we = 1'b1; end
                    c_FN_OR:   begin w_alu = w_rs_val | w_rt_val;    w_reg_we = 1'b1; end
                    c_FN_XOR:  begin w_alu = w_rs_val ^ w_rt_val;    w_reg_we = 1'b1; end
                    c_FN_NOR:  begin w_alu = ~(w_rs_val | w_rt_val); w_reg_we = 1'b1; end
                    c_FN_SLT:  begin w_alu = {31'b0, $signed(w_rs_val) < $signed(w_rt_val)}; w_reg_we = 1'b1; end
                    c_FN_SLTU: begin w_alu = {31'b0, w_rs_val < w_rt_val}; w_reg_we = 1'b1; end
                    default:   ;
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU: begin w_alu = w_rs_val + w_sext; w_wa = w_rt; w_reg_we = 1'b1; end
            c_OP_SLTI:  begin w_alu = {31'b0, $signed(w_rs_val) < $signed(w_sext)}; w_wa = w_rt; w_reg_we = 1'b1; end
            c_OP_SLTIU: begin w_alu = {31'b0, w_rs_val < w_sext}; w_wa = w_rt; w_reg_we = 1'b1; end
            c_OP_ANDI:  begin w_alu = w_rs_val & w_zext; w_wa = w_rt; w_reg_we = 1'b1; end
            c_OP_ORI:   begin w_alu = w_rs_val | w_zext; w_wa = w_rt; w_reg_we = 1'b1; end
            c_OP_XORI:  begin w_alu = w_rs_val ^ w_zext; w_wa = w_rt; w_reg_we = 1'b1; end
            c_OP_LUI:   begin w_alu = {w_imm, 16'h0000}; w_wa = w_rt; w_reg_we = 1'b1; end
            c_OP_LW:    begin w_alu = w_rs_val + w_sext; w_wa = w_rt; w_reg_we = 1'b1; w_load = 1'b1; end
            c_OP_SW:    begin w_alu = w_rs_val + w_sext; w_mem_we = 1'b1; end
            c_OP_BEQ: if (w_rs_val == w_rt_val) w_next_pc = w_pc_plus4 + {w_sext[29:0], 2'b00};
            c_OP_BNE: if (w_rs_val != w_rt_val) w_next_pc = w_pc_plus4 + {w_sext[29:0], 2'b00};
            c_OP_J:   w_next_pc = {w_pc_plus4[31:28], w_target, 2'b00};
            c_OP_JAL: begin
                w_next_pc = {w_pc_plus4[31:28], w_target, 2'b00};
                w_wa      = 5'd31;
                w_link    = 1'b1;
                w_reg_we  = 1'b1;
            end
            default: ;
        endcase
    end

    // Kept out of the decoder block: load data depends on the ALU address.
    assign w_wd = w_link ? w_pc_plus4 : (w_load ? w_dmem_rdata : w_alu);

endmodule
`default_nettype wire

// File: tb/tb_mips_r2000_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_r2000_core
//  Description : Self-checking bench for mips_r2000_core. Preloads programs
//                into instruction memory hierarchically, drives CLK/RST and
//                compares PC, registers and data memory against constants
//                and an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_r2000_core;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] prog [$];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:1023];

    mips_r2000_core dut (
        .CLK (CLK),
        .RST (RST)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 1024; i++) dut.U_InstructionMemory.IMem[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) dut.U_InstructionMemory.IMem[i] = prog[i];
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rf(input int i);
        return dut.U_RegFile.regs[i];
    endfunction

    // Instruction-level reference: one call retires one instruction of a
    // straight-line program (no control transfer).
    task automatic model_exec(input logic [31:0] w);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b, se, ze, ea;
        int          dst;
        logic [31:0] res;
        bit          wr;
        op = w[31:26]; fn = w[5:0];
        a  = m_reg[w[25:21]];
        b  = m_reg[w[20:16]];
        se = {{16{w[15]}}, w[15:0]};
        ze = {16'h0, w[15:0]};
        ea = a + se;
        wr = 1'b1; dst = w[20:16]; res = 32'h0;
        case (op)
            6'h00: begin
                dst = w[15:11];
                case (fn)
                    6'h00: res = b << w[10:6];
                    6'h02: res = b >> w[10:6];
                    6'h03: res = $unsigned($signed(b) >>> w[10:6]);
                    6'h21: res = a + b;
                    6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            6'h09: res = a + se;
            6'h0A: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            6'h0B: res = (a < se) ? 32'd1 : 32'd0;
            6'h0C: res = a & ze;
            6'h0D: res = a | ze;
            6'h0E: res = a ^ ze;
            6'h0F: res = {w[15:0], 16'h0};
            6'h23: res = m_mem[ea[11:2]];
            6'h2B: begin m_mem[ea[11:2]] = b; wr = 1'b0; end
            default: wr = 1'b0;
        endcase
        if (wr && dst != 0) m_reg[dst] = res;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] beq_word;
        int          n_rand;
        int          pick;
        logic [5:0]  rops [11];
        logic [5:0]  iops [7];
        rops = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        iops = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

        // ---- Reset and sequential fetch ----
        prog = {enc_i(6'h0D, 0, 1, 16'h1234)};
        load_prog();
        do_reset();
        check("reset_pc", dut.U_PCU.PCRegDataOut, 32'h0);
        check("reset_instr", dut.instr, enc_i(6'h0D, 0, 1, 16'h1234));
        step(3);
        check("pc_after_3", dut.U_PCU.PCRegDataOut, 32'hC);

        // ---- ALU ----
        prog = {enc_i(6'h0D, 0, 1, 16'h1234), enc_i(6'h0F, 0, 2, 16'h8000),
                enc_r(6'h21, 1, 2, 3, 0),     enc_r(6'h23, 1, 1, 4, 0),
                enc_r(6'h2A, 2, 1, 5, 0),     enc_r(6'h2B, 2, 1, 6, 0)};
        load_prog();
        do_reset();
        step(6);
        check("alu_addu", rf(3), 32'h8000_1234);
        check("alu_subu", rf(4), 32'h0);
        check("alu_slt",  rf(5), 32'h1);
        check("alu_sltu", rf(6), 32'h0);

        // ---- Memory ----
        prog = {enc_i(6'h0D, 0, 1, 16'h00AB), enc_i(6'h2B, 0, 1, 16'h0008),
                enc_i(6'h23, 0, 2, 16'h0008)};
        load_prog();
        do_reset();
        step(3);
        check("mem_lw", rf(2), 32'hAB);
        check("mem_dmem2", dut.U_DataMemory.DMem[2], 32'hAB);

        // ---- Branches, jumps, link, $0 protection ----
        beq_word = enc_i(6'h04, 0, 0, 16'd2);
        prog = {32'h0, 32'h0, 32'h0, 32'h0,
                beq_word,                          // 0x10
                enc_i(6'h0D, 0, 7, 16'h0001),      // 0x14 skipped
                enc_i(6'h0D, 0, 8, 16'h0002),      // 0x18 skipped
                enc_i(6'h05, 0, 0, 16'd5),         // 0x1C bne not taken
                enc_j(6'h03, 26'h10),              // 0x20 jal 0x40
                enc_i(6'h09, 0, 0, 16'd5)};        // 0x24 addiu $0,$0,5
        for (int i = prog.size(); i < 16; i++) prog.push_back(32'h0);
        prog.push_back(enc_r(6'h08, 31, 0, 0, 0)); // 0x40 jr $31
        load_prog();
        do_reset();
        step(5);
        check("beq_taken_pc", dut.U_PCU.PCRegDataOut, 32'h1C);
        check("beq_skip_r7", rf(7), 32'h0);
        check("beq_skip_r8", rf(8), 32'h0);
        step(1);
        check("bne_not_taken_pc", dut.U_PCU.PCRegDataOut, 32'h20);
        step(1);
        check("jal_pc", dut.U_PCU.PCRegDataOut, 32'h40);
        check("jal_r31", rf(31), 32'h24);
        step(1);
        check("jr_pc", dut.U_PCU.PCRegDataOut, 32'h24);
        step(1);
        check("r0_protect", rf(0), 32'h0);
        check("after_addiu_pc", dut.U_PCU.PCRegDataOut, 32'h28);

        // A low pulse that no rising edge samples must not reset the core.
        @(negedge CLK);
        RST = 1'b0;
        #2;
        RST = 1'b1;
        step(1);
        check("glitch_no_reset_pc", dut.U_PCU.PCRegDataOut, 32'h2C);
        check("glitch_keeps_r31", rf(31), 32'h24);

        // ---- Reset mid-program ----
        do_reset();
        check("midreset_pc", dut.U_PCU.PCRegDataOut, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("midreset_r%0d", i), rf(i), 32'h0);
        check("midreset_imem", dut.U_InstructionMemory.IMem[4], beq_word);
        check("midreset_dmem", dut.U_DataMemory.DMem[2], 32'hAB);
        // Held reset: PC pinned at zero, no writes.
        @(negedge CLK);
        RST = 1'b0;
        step(3);
        check("held_reset_pc", dut.U_PCU.PCRegDataOut, 32'h0);
        check("held_reset_r31", rf(31), 32'h0);
        RST = 1'b1;
        step(1);
        check("release_pc", dut.U_PCU.PCRegDataOut, 32'h4);

        // ---- Randomized straight-line program vs reference model ----
        n_rand = 80;
        prog = {};
        for (int i = 0; i < n_rand; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 40)
                w = enc_r(rops[$urandom_range(0, 10)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 31)));
            else if (pick < 80)
                w = enc_i(iops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 16'($urandom));
            else if (pick < 88)
                w = enc_i(6'h2B, 0, 5'($urandom_range(0, 7)), 16'($urandom_range(0, 63)));
            else if (pick < 96)
                w = enc_i(6'h23, 0, 5'($urandom_range(0, 7)), 16'($urandom_range(0, 63)));
            else
                w = {6'h3F, 26'($urandom)};       // unrecognised opcode
            prog.push_back(w);
        end
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            m_mem[i] = 32'h0;
            dut.U_DataMemory.DMem[i] = 32'h0;
        end
        foreach (prog[i]) model_exec(prog[i]);
        load_prog();
        do_reset();
        step(n_rand);
        check("rand_pc", dut.U_PCU.PCRegDataOut, 32'(4 * n_rand));
        for (int i = 0; i < 8; i++) check($sformatf("rand_r%0d", i), rf(i), m_reg[i]);
        for (int i = 0; i < 16; i++) check($sformatf("rand_dmem%0d", i), dut.U_DataMemory.DMem[i], m_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
